// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Imported by the register file top and by its write-select decoder.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 5;

  // Highest address; it is the hardwired zero register when that option is enabled.
  function automatic int zero_reg_addr(input int aw);
    return (1 << aw) - 1;
  endfunction

  // Low bit index of port k inside a packed multi-port bus of w-bit lanes.
  function automatic int port_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_mp_one_hot_decoder.sv
// Binary-to-one-hot decoder producing the per-register write enables.
// When enable is low every output bit is 0.
module one_hot_decoder #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         enable,
  input  logic [ADDR_WIDTH-1:0]        select,
  output logic [(1 << ADDR_WIDTH)-1:0] out
);

  always_comb begin
    out = '0;
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) begin
      out[i] = enable && (select == ADDR_WIDTH'(i));
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Register file with one synchronous write port and NUM_READ combinational
// read ports, optional hardwired zero register and write-to-read bypass.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           write_en,
  input  logic [ADDR_WIDTH-1:0]          write_addr,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  output logic                           write_ack
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZADDR = ADDR_WIDTH'(zero_reg_addr(ADDR_WIDTH));

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  zero_wr;
  logic                  wr_acc;
  logic [DEPTH-1:0]      wr_sel;

  // A write aimed at the zero register is not accepted: no store, no ack.
  assign zero_wr = (ZERO_REG != 0) && (write_addr == ZADDR);
  assign wr_acc  = write_en && !zero_wr;

  one_hot_decoder #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dec (
    .enable(wr_acc),
    .select(write_addr),
    .out   (wr_sel)
  );

  // Write stage: reset wins over a coincident write.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_ack <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      write_ack <= wr_acc;
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= write_data;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;

    assign ra = read_addr[port_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];

    // Zero-register forcing is applied last so it also overrides the bypass.
    always_comb begin
      rd = regs[ra];
      if ((BYPASS != 0) && wr_acc && !reset && (ra == write_addr)) begin
        rd = write_data;
      end
      if ((ZERO_REG != 0) && (ra == ZADDR)) begin
        rd = '0;
      end
    end

    assign read_data[port_lo(k, DATA_WIDTH) +: DATA_WIDTH] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations driven by directed vectors,
// checked every cycle against an array model plus hand-computed literals.
module tb_regfile_mp;

  logic clock = 1'b0;
  logic reset;

  // u0: default (zero reg + bypass); u1: no zero reg, no bypass; same stimulus
  logic         we01;
  logic [4:0]   wa01;
  logic [63:0]  wd01;
  logic [9:0]   ra01;
  logic [127:0] rd0, rd1;
  logic         ack0, ack1;

  // u2: 16-bit, 8 registers, 3 read ports
  logic         we2;
  logic [2:0]   wa2;
  logic [15:0]  wd2;
  logic [8:0]   ra2;
  logic [47:0]  rd2;
  logic         ack2;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  regfile_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)) u0 (
    .clock(clock), .reset(reset), .write_en(we01), .write_addr(wa01), .write_data(wd01),
    .read_addr(ra01), .read_data(rd0), .write_ack(ack0));

  regfile_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(0), .BYPASS(0)) u1 (
    .clock(clock), .reset(reset), .write_en(we01), .write_addr(wa01), .write_data(wd01),
    .read_addr(ra01), .read_data(rd1), .write_ack(ack1));

  regfile_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_READ(3), .ZERO_REG(1), .BYPASS(1)) u2 (
    .clock(clock), .reset(reset), .write_en(we2), .write_addr(wa2), .write_data(wd2),
    .read_addr(ra2), .read_data(rd2), .write_ack(ack2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m0 [32];
  logic [63:0] m1 [32];
  logic [15:0] m2 [8];
  logic        am0, am1, am2;
  logic        live = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m0[i] <= '0;
        m1[i] <= '0;
      end
      for (int i = 0; i < 8; i++) m2[i] <= '0;
      am0 <= 1'b0; am1 <= 1'b0; am2 <= 1'b0;
      live <= 1'b1;
    end else begin
      am0 <= we01 && (wa01 != 5'd31);
      if (we01 && (wa01 != 5'd31)) m0[wa01] <= wd01;
      am1 <= we01;
      if (we01) m1[wa01] <= wd01;
      am2 <= we2 && (wa2 != 3'd7);
      if (we2 && (wa2 != 3'd7)) m2[wa2] <= wd2;
    end
  end

  // Every-cycle comparison, between edges while inputs are stable
  always @(negedge clock) begin
    logic [4:0]  a5;
    logic [2:0]  a3;
    logic [63:0] e64;
    logic [15:0] e16;
    if (live) begin
      for (int k = 0; k < 2; k++) begin
        a5 = ra01[k*5 +: 5];
        if (a5 == 5'd31) e64 = '0;
        else if (we01 && !reset && a5 == wa01) e64 = wd01;
        else e64 = m0[a5];
        chk($sformatf("u0_rd%0d", k), rd0[k*64 +: 64], e64);
        chk($sformatf("u1_rd%0d", k), rd1[k*64 +: 64], m1[a5]);
      end
      for (int k = 0; k < 3; k++) begin
        a3 = ra2[k*3 +: 3];
        if (a3 == 3'd7) e16 = '0;
        else if (we2 && !reset && a3 == wa2) e16 = wd2;
        else e16 = m2[a3];
        chk($sformatf("u2_rd%0d", k), 64'(rd2[k*16 +: 16]), 64'(e16));
      end
      chk("u0_ack", 64'(ack0), 64'(am0));
      chk("u1_ack", 64'(ack1), 64'(am1));
      chk("u2_ack", 64'(ack2), 64'(am2));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    we01 = 1'b0; wa01 = '0; wd01 = '0; ra01 = '0;
    we2 = 1'b0;  wa2 = '0;  wd2 = '0;  ra2 = '0;
    step(); step();
    reset = 1'b0;

    // reset clears r3
    we01 = 1'b1; wa01 = 5'd3; wd01 = 64'hDEAD_BEEF; ra01 = {5'd0, 5'd3};
    step();
    we01 = 1'b0;
    mid();
    chk("lit_r3_written", rd0[63:0], 64'hDEAD_BEEF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    mid();
    chk("lit_r3_after_reset", rd0[63:0], 64'h0);
    chk("lit_ack_after_reset", 64'(ack0), 64'h0);

    // basic write/read
    we01 = 1'b1; wa01 = 5'd7; wd01 = 64'h1234; ra01 = {5'd6, 5'd7};
    step();
    we01 = 1'b0;
    mid();
    chk("lit_r7", rd0[63:0], 64'h1234);
    chk("lit_r6", rd0[127:64], 64'h0);
    chk("lit_ack_r7", 64'(ack0), 64'h1);
    step();
    mid();
    chk("lit_ack_drop", 64'(ack0), 64'h0);

    // zero register
    we01 = 1'b1; wa01 = 5'd31; wd01 = 64'hFFFF; ra01 = {5'd31, 5'd31};
    step();
    we01 = 1'b0;
    mid();
    chk("lit_r31_zr", rd0[63:0], 64'h0);
    chk("lit_ack_r31_zr", 64'(ack0), 64'h0);
    chk("lit_r31_nozr", rd1[63:0], 64'hFFFF);
    chk("lit_ack_r31_nozr", 64'(ack1), 64'h1);

    // bypass
    we01 = 1'b1; wa01 = 5'd5; wd01 = 64'h11;
    step();
    wd01 = 64'h22; ra01 = {5'd5, 5'd5};
    mid();
    chk("lit_byp_p0", rd0[63:0], 64'h22);
    chk("lit_byp_p1", rd0[127:64], 64'h22);
    chk("lit_nobyp_before", rd1[63:0], 64'h11);
    step();
    we01 = 1'b0;
    mid();
    chk("lit_nobyp_after", rd1[63:0], 64'h22);

    // reset priority over write, bypass suppressed
    reset = 1'b1; we01 = 1'b1; wa01 = 5'd9; wd01 = 64'hAA; ra01 = {5'd9, 5'd9};
    mid();
    chk("lit_rst_byp", rd0[63:0], 64'h0);
    step();
    reset = 1'b0; we01 = 1'b0;
    mid();
    chk("lit_r9_after", rd0[63:0], 64'h0);
    chk("lit_r9_after_u1", rd1[63:0], 64'h0);

    // sweep on the 16-bit, 3-port instance
    for (int i = 0; i < 8; i++) begin
      we2 = 1'b1; wa2 = 3'(i); wd2 = 16'(i + 'h100);
      ra2 = {3'(i), 3'(i), 3'(i)};
      step();
    end
    we2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra2 = {3'(i), 3'(i), 3'(i)};
      mid();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("lit_sweep_r%0d_p%0d", i, k), 64'(rd2[k*16 +: 16]),
            (i == 7) ? 64'h0 : 64'(i + 'h100));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
